// File: rtl/digpot_pkg.sv
// digpot_pkg: shared definitions for the digital-pot tracker.
//   - default geometry (POT_STEPS_DEF, MAX_BURST_DEF)
//   - command word field positions and direction encodings
//   - tracker state encoding and command word struct
package digpot_pkg;

    localparam int POT_STEPS_DEF = 100;
    localparam int MAX_BURST_DEF = 127;

    localparam int CMD_DIR_BIT = 7;
    localparam int CMD_CNT_MSB = 6;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_HOME_ISSUE = 2'd1,
        ST_ISSUE      = 2'd2,
        ST_WAIT       = 2'd3
    } state_e;

    // Matches cmd_o layout: [7] direction, [6:0] step count.
    typedef struct packed {
        logic       dir;
        logic [CMD_CNT_MSB:0] cnt;
    } cmd_t;

endpackage

// File: rtl/digpot_step_calc.sv
// digpot_step_calc: combinational helper for the tracker.
//   target_raw_i : raw target from the host, clamped to POT_STEPS-1 on tgt_clamp_o
//   tgt_i/pos_i  : latched target and tracked wiper position
//   dir_o        : 1 = move up (tgt > pos)
//   cnt_o        : |tgt - pos| limited to MAX_BURST
//   at_target_o  : tgt == pos
module digpot_step_calc
    import digpot_pkg::*;
#(
    parameter int POT_STEPS = POT_STEPS_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic [6:0] target_raw_i,
    input  logic [6:0] tgt_i,
    input  logic [6:0] pos_i,
    output logic [6:0] tgt_clamp_o,
    output logic       dir_o,
    output logic [6:0] cnt_o,
    output logic       at_target_o
);

    localparam logic [6:0] TOP_POS = 7'(POT_STEPS - 1);
    localparam logic [7:0] BURST   = 8'(MAX_BURST);

    logic [7:0] mag;

    always_comb begin
        tgt_clamp_o = (target_raw_i > TOP_POS) ? TOP_POS : target_raw_i;
        dir_o       = (tgt_i > pos_i) ? DIR_UP : DIR_DOWN;
        // 8-bit subtraction ordered by direction so it never wraps.
        mag         = dir_o ? ({1'b0, tgt_i} - {1'b0, pos_i})
                            : ({1'b0, pos_i} - {1'b0, tgt_i});
        cnt_o       = (mag > BURST) ? BURST[6:0] : mag[6:0];
        at_target_o = (tgt_i == pos_i);
    end

endmodule

// File: rtl/digpot_tracker.sv
// digpot_tracker: absolute-position front end for the digital-pot stepping
// engine. Keeps a shadow copy of the wiper (the pot cannot report it),
// homes the wiper to 0 when required and turns target changes into
// {direction, count} step bursts over a valid/ready/done handshake.
//   clk, reset_n     : clock, asynchronous active-low reset
//   target_i/_we_i   : desired position and its single-cycle write strobe
//   home_i           : single-cycle re-home request
//   cmd_o/cmd_valid_o: step command to the engine, cmd_ready_i accepts it
//   cmd_done_i       : engine finished the accepted burst
//   position_o       : tracked wiper position, homed_o says it is trustworthy
//   busy_o           : command outstanding or target not yet reached
module digpot_tracker
    import digpot_pkg::*;
#(
    parameter int POT_STEPS     = POT_STEPS_DEF,
    parameter int MAX_BURST     = MAX_BURST_DEF,
    parameter bit HOME_ON_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] target_i,
    input  logic       target_we_i,
    input  logic       home_i,
    output logic [7:0] cmd_o,
    output logic       cmd_valid_o,
    input  logic       cmd_ready_i,
    input  logic       cmd_done_i,
    output logic [6:0] position_o,
    output logic       homed_o,
    output logic       busy_o
);

    localparam state_e RST_STATE = HOME_ON_RESET ? ST_HOME_ISSUE : ST_IDLE;

    state_e     state_q, state_d;
    cmd_t       cmd_q, cmd_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic [6:0] pos_q, pos_d;
    logic [6:0] tgt_q, tgt_d;
    logic       homed_q, homed_d;
    logic       home_pend_q, home_pend_d;
    logic       homing_q, homing_d;
    logic       busy_q, busy_d;

    logic [6:0] tgt_clamp;
    logic       calc_dir;
    logic [6:0] calc_cnt;
    logic       at_target;

    digpot_step_calc #(
        .POT_STEPS (POT_STEPS),
        .MAX_BURST (MAX_BURST)
    ) u_calc (
        .target_raw_i (target_i),
        .tgt_i        (tgt_q),
        .pos_i        (pos_q),
        .tgt_clamp_o  (tgt_clamp),
        .dir_o        (calc_dir),
        .cnt_o        (calc_cnt),
        .at_target_o  (at_target)
    );

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        pos_d       = pos_q;
        tgt_d       = tgt_q;
        homed_d     = homed_q;
        home_pend_d = home_pend_q;
        homing_d    = homing_q;

        case (state_q)
            ST_IDLE: begin
                if (home_pend_q) begin
                    state_d = ST_HOME_ISSUE;
                end else if (!at_target) begin
                    cmd_d       = '{dir: calc_dir, cnt: calc_cnt};
                    cmd_valid_d = 1'b1;
                    homing_d    = 1'b0;
                    state_d     = ST_ISSUE;
                end
            end
            ST_HOME_ISSUE: begin
                // Full-scale down burst: the engine saturates at 0, so this
                // lands on 0 from any physical position.
                cmd_d       = '{dir: DIR_DOWN, cnt: 7'(POT_STEPS)};
                cmd_valid_d = 1'b1;
                homed_d     = 1'b0;
                home_pend_d = 1'b0;
                homing_d    = 1'b1;
                state_d     = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (cmd_valid_q && cmd_ready_i) begin
                    cmd_valid_d = 1'b0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cmd_done_i) begin
                    if (homing_q) begin
                        pos_d   = '0;
                        homed_d = 1'b1;
                    end else if (cmd_q.dir == DIR_UP) begin
                        pos_d = pos_q + cmd_q.cnt;
                    end else begin
                        pos_d = pos_q - cmd_q.cnt;
                    end
                    homing_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Host-side writes are accepted in every state; a home request
        // arriving while HOME_ISSUE clears the flag still wins.
        if (target_we_i) tgt_d = tgt_clamp;
        if (home_i)      home_pend_d = 1'b1;

        busy_d = (state_d != ST_IDLE) || (tgt_d != pos_d) || home_pend_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RST_STATE;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            pos_q       <= '0;
            tgt_q       <= '0;
            homed_q     <= !HOME_ON_RESET;
            home_pend_q <= HOME_ON_RESET;
            homing_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            pos_q       <= pos_d;
            tgt_q       <= tgt_d;
            homed_q     <= homed_d;
            home_pend_q <= home_pend_d;
            homing_q    <= homing_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_o       = cmd_q;
    assign cmd_valid_o = cmd_valid_q;
    assign position_o  = pos_q;
    assign homed_o     = homed_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_digpot_tracker.sv
// Bench for digpot_tracker: default instance (homes on reset, MAX_BURST=127)
// plus a second instance with MAX_BURST=50 and no homing on reset.
module tb_digpot_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: defaults
    logic       a_rst_n, a_we, a_home, a_ready, a_done;
    logic [6:0] a_tgt;
    logic [7:0] a_cmd;
    logic       a_valid, a_homed, a_busy;
    logic [6:0] a_pos;

    // instance B: MAX_BURST=50, HOME_ON_RESET=0
    logic       b_rst_n, b_we, b_home, b_ready, b_done;
    logic [6:0] b_tgt;
    logic [7:0] b_cmd;
    logic       b_valid, b_homed, b_busy;
    logic [6:0] b_pos;

    digpot_tracker u_a (
        .clk(clk), .reset_n(a_rst_n), .target_i(a_tgt), .target_we_i(a_we),
        .home_i(a_home), .cmd_o(a_cmd), .cmd_valid_o(a_valid),
        .cmd_ready_i(a_ready), .cmd_done_i(a_done), .position_o(a_pos),
        .homed_o(a_homed), .busy_o(a_busy)
    );

    digpot_tracker #(.POT_STEPS(100), .MAX_BURST(50), .HOME_ON_RESET(1'b0)) u_b (
        .clk(clk), .reset_n(b_rst_n), .target_i(b_tgt), .target_we_i(b_we),
        .home_i(b_home), .cmd_o(b_cmd), .cmd_valid_o(b_valid),
        .cmd_ready_i(b_ready), .cmd_done_i(b_done), .position_o(b_pos),
        .homed_o(b_homed), .busy_o(b_busy)
    );

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];

    typedef struct {
        logic [6:0] tgt;
        logic [7:0] cmd;
        logic [6:0] pos;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Wait (bounded) for a command on A, compare it with the scoreboard head,
    // then complete the valid/ready handshake.
    task automatic accept_a(input string name);
        int n = 0;
        logic [7:0] e;
        while (!a_valid && n < 30) begin tick(); n++; end
        if (!a_valid) begin
            checks++; failures++;
            $display("FAIL %s: no cmd_valid within 30 cycles", name);
            return;
        end
        if (exp_a.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s: unexpected cmd %0h", name, a_cmd);
        end else begin
            e = exp_a.pop_front();
            chk(name, {24'd0, a_cmd}, {24'd0, e});
        end
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        chk({name, "_vdrop"}, {31'd0, a_valid}, 32'd0);
    endtask

    task automatic done_a();
        tick();
        a_done = 1'b1;
        tick();
        a_done = 1'b0;
    endtask

    task automatic serve_b(input string name);
        int n = 0;
        logic [7:0] e;
        while (!b_valid && n < 30) begin tick(); n++; end
        if (!b_valid) begin
            checks++; failures++;
            $display("FAIL %s: no cmd_valid within 30 cycles", name);
            return;
        end
        e = (exp_b.size() != 0) ? exp_b.pop_front() : 8'h00;
        chk(name, {24'd0, b_cmd}, {24'd0, e});
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        tick();
        b_done = 1'b1;
        tick();
        b_done = 1'b0;
    endtask

    initial begin
        vecs[0] = '{tgt: 7'd40,  cmd: 8'hA8, pos: 7'd40};
        vecs[1] = '{tgt: 7'd10,  cmd: 8'h1E, pos: 7'd10};
        vecs[2] = '{tgt: 7'd120, cmd: 8'hD9, pos: 7'd99};
        vecs[3] = '{tgt: 7'd0,   cmd: 8'h63, pos: 7'd0};

        a_rst_n = 0; a_we = 0; a_home = 0; a_ready = 0; a_done = 0; a_tgt = 0;
        b_rst_n = 0; b_we = 0; b_home = 0; b_ready = 0; b_done = 0; b_tgt = 0;
        tick(); tick();

        // reset state
        chk("rst_cmd",   {24'd0, a_cmd},   32'd0);
        chk("rst_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_pos",   {25'd0, a_pos},   32'd0);
        chk("rst_homed", {31'd0, a_homed}, 32'd0);
        chk("rst_busy",  {31'd0, a_busy},  32'd0);

        // release; homing command must appear and hold while not ready
        a_rst_n = 1; b_rst_n = 1;
        exp_a.push_back(8'h64);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("home_hold_cmd",   {24'd0, a_cmd},   32'h64);
            chk("home_hold_valid", {31'd0, a_valid}, 32'd1);
            tick();
        end
        chk("home_homed_lo", {31'd0, a_homed}, 32'd0);
        accept_a("home_cmd");
        done_a();
        chk("home_pos",   {25'd0, a_pos},   32'd0);
        chk("home_homed", {31'd0, a_homed}, 32'd1);
        chk("home_busy",  {31'd0, a_busy},  32'd0);

        // table-driven single bursts
        foreach (vecs[i]) begin
            a_tgt = vecs[i].tgt; a_we = 1'b1;
            exp_a.push_back(vecs[i].cmd);
            tick();
            a_we = 1'b0;
            chk("lat_not_yet", {31'd0, a_valid}, 32'd0);
            chk("lat_busy",    {31'd0, a_busy},  32'd1);
            tick();
            chk("lat_valid",   {31'd0, a_valid}, 32'd1);
            accept_a("vec_cmd");
            done_a();
            chk("vec_pos",  {25'd0, a_pos},  {25'd0, vecs[i].pos});
            chk("vec_busy", {31'd0, a_busy}, 32'd0);
        end

        // writes and home request during WAIT are deferred
        a_tgt = 7'd30; a_we = 1'b1;
        exp_a.push_back(8'h9E);
        tick();
        a_we = 1'b0;
        accept_a("wait_cmd");
        a_tgt = 7'd50; a_we = 1'b1; tick();
        a_tgt = 7'd20; tick();
        a_we = 1'b0; a_home = 1'b1; tick();
        a_home = 1'b0;
        chk("wait_still_pos", {25'd0, a_pos}, 32'd0);
        exp_a.push_back(8'h64);
        exp_a.push_back(8'h94);
        done_a();
        chk("wait_pos", {25'd0, a_pos}, 32'd30);
        accept_a("rehome_cmd");
        chk("rehome_homed_lo", {31'd0, a_homed}, 32'd0);
        done_a();
        chk("rehome_pos",   {25'd0, a_pos},   32'd0);
        chk("rehome_homed", {31'd0, a_homed}, 32'd1);
        accept_a("post_home_cmd");
        done_a();
        chk("post_home_pos",  {25'd0, a_pos},  32'd20);
        chk("post_home_busy", {31'd0, a_busy}, 32'd0);

        // reset in the middle of a burst
        a_tgt = 7'd60; a_we = 1'b1;
        exp_a.push_back(8'hA8);
        tick();
        a_we = 1'b0;
        accept_a("mid_cmd");
        a_rst_n = 1'b0;
        #1;
        chk("mid_rst_cmd",   {24'd0, a_cmd},   32'd0);
        chk("mid_rst_valid", {31'd0, a_valid}, 32'd0);
        chk("mid_rst_pos",   {25'd0, a_pos},   32'd0);
        chk("mid_rst_homed", {31'd0, a_homed}, 32'd0);
        chk("mid_rst_busy",  {31'd0, a_busy},  32'd0);
        tick();
        a_rst_n = 1'b1;
        exp_a.delete();
        exp_a.push_back(8'h64);
        accept_a("rst_rehome_cmd");
        done_a();
        chk("rst_rehome_pos",   {25'd0, a_pos},   32'd0);
        chk("rst_rehome_homed", {31'd0, a_homed}, 32'd1);
        // stray done in IDLE must be ignored
        a_done = 1'b1; tick(); a_done = 1'b0; tick();
        chk("stray_pos",   {25'd0, a_pos},   32'd0);
        chk("stray_valid", {31'd0, a_valid}, 32'd0);
        chk("stray_busy",  {31'd0, a_busy},  32'd0);

        // instance B: no homing on reset, burst split at 50
        chk("b_homed", {31'd0, b_homed}, 32'd1);
        chk("b_valid", {31'd0, b_valid}, 32'd0);
        b_tgt = 7'd99; b_we = 1'b1;
        exp_b.push_back(8'hB2);
        exp_b.push_back(8'hB1);
        tick();
        b_we = 1'b0;
        serve_b("b_split1");
        chk("b_mid_pos",  {25'd0, b_pos},  32'd50);
        chk("b_mid_busy", {31'd0, b_busy}, 32'd1);
        serve_b("b_split2");
        chk("b_end_pos",  {25'd0, b_pos},  32'd99);
        chk("b_end_busy", {31'd0, b_busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
